// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master round-robin Wishbone classic arbiter with a bus watchdog
module wb_arbiter2 #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 8
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [1:0]  m_cyc_i,
   input  logic [1:0]  m_stb_i,
   input  logic [1:0]  m_we_i,
   input  logic [63:0] m_adr_i,
   input  logic [7:0]  m_sel_i,
   input  logic [63:0] m_dat_i,
   output logic [63:0] m_dat_o,
   output logic [1:0]  m_ack_o,
   output logic [1:0]  m_err_o,
   output logic [1:0]  m_rty_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   output logic        s_we_o,
   output logic [31:0] s_adr_o,
   output logic [3:0]  s_sel_o,
   output logic [31:0] s_dat_o,
   input  logic [31:0] s_dat_i,
   input  logic        s_ack_i,
   input  logic        s_err_i,
   input  logic        s_rty_i,
   output logic        timeout_o
);
   typedef enum logic [1:0] {IDLE, BUSY, TOERR} state_t;
   localparam bit WD_EN = TIMEOUT_CYCLES > 0;
   localparam logic [CNT_W-1:0] LIM = CNT_W'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);
   state_t state, state_n;
   logic owner, owner_n, last, last_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic busy, toerr, term;
   logic [1:0] own;
   assign busy  = state == BUSY;
   assign toerr = state == TOERR;
   assign term  = s_ack_i | s_err_i | s_rty_i;
   assign own   = {owner, ~owner};
   assign s_cyc_o = busy & m_cyc_i[owner];
   assign s_stb_o = busy & m_stb_i[owner];
   assign s_we_o  = busy & m_we_i[owner];
   assign s_adr_o = busy ? (owner ? m_adr_i[63:32] : m_adr_i[31:0]) : 32'h0;
   assign s_sel_o = busy ? (owner ? m_sel_i[7:4] : m_sel_i[3:0]) : 4'h0;
   assign s_dat_o = busy ? (owner ? m_dat_i[63:32] : m_dat_i[31:0]) : 32'h0;
   assign m_dat_o = {2{s_dat_i}};
   assign m_ack_o = own & {2{busy & s_ack_i}};
   assign m_err_o = own & {2{(busy & s_err_i) | toerr}};
   assign m_rty_o = own & {2{busy & s_rty_i}};
   assign timeout_o = toerr;
   // state register; reset leaves last=1 so master 0 wins the first tie
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
         owner <= 1'b0;
         last  <= 1'b1;
         cnt   <= '0;
      end else begin
         state <= state_n;
         owner <= owner_n;
         last  <= last_n;
         cnt   <= cnt_n;
      end
   end
   // arbitration, CYC-long grant hold and watchdog counting
   always_comb begin
      state_n = state;
      owner_n = owner;
      last_n  = last;
      cnt_n   = cnt;
      case (state)
         IDLE: begin
            if (|m_cyc_i) begin
               state_n = BUSY;
               owner_n = &m_cyc_i ? ~last : m_cyc_i[1];
            end
         end
         BUSY: begin
            if (!m_cyc_i[owner]) begin
               state_n = IDLE;
               last_n  = owner;
               cnt_n   = '0;
            end else if (!s_stb_o || term || !WD_EN) begin
               cnt_n = '0;
            end else if (cnt == LIM) begin
               state_n = TOERR;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         TOERR: begin
            cnt_n   = '0;
            state_n = m_cyc_i[owner] ? BUSY : IDLE;
            last_n  = m_cyc_i[owner] ? last : owner;
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: directed scoreboard bench for the two-master Wishbone arbiter
module tb_wb_arbiter2;
   typedef struct packed {
      logic [1:0]  ack;
      logic [1:0]  err;
      logic [1:0]  rty;
      logic        to;
      logic        we;
      logic [31:0] adr;
      logic [63:0] dat;
   } ev_t;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic [1:0]  m_cyc_i = '0, m_stb_i = '0, m_we_i = '0;
   logic [63:0] m_adr_i = '0, m_dat_i = '0;
   logic [7:0]  m_sel_i = '0;
   logic [63:0] m_dat_o;
   logic [1:0]  m_ack_o, m_err_o, m_rty_o;
   logic        s_cyc_o, s_stb_o, s_we_o, timeout_o;
   logic [31:0] s_adr_o, s_dat_o;
   logic [3:0]  s_sel_o;
   logic [31:0] s_dat_i = '0;
   logic        ack_r = 1'b0, auto_ack = 1'b0, s_err_i = 1'b0, s_rty_i = 1'b0;
   logic        s_ack_i;
   int checks = 0, errors = 0;
   ev_t sb[$];

   assign s_ack_i = ack_r | (auto_ack & s_stb_o);

   always #5 clk_i = ~clk_i;

   wb_arbiter2 #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
      .m_adr_i(m_adr_i), .m_sel_i(m_sel_i), .m_dat_i(m_dat_i),
      .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
      .timeout_o(timeout_o)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic ev_t mk(input logic [1:0] ack, input logic [1:0] err, input logic [1:0] rty,
                              input logic to, input logic we, input logic [31:0] adr, input logic [31:0] dat);
      return '{ack, err, rty, to, we, adr, {2{dat}}};
   endfunction

   function automatic logic [31:0] base(input int m, input int r);
      return 32'h2000_0000 + 32'(m * 256 + r * 4);
   endfunction

   // monitor: every termination/timeout the DUT presents is matched against the next expected event
   always @(negedge clk_i) begin
      ev_t act, exp;
      if (|{m_ack_o, m_err_o, m_rty_o, timeout_o}) begin
         act = '{m_ack_o, m_err_o, m_rty_o, timeout_o, s_we_o, s_adr_o, m_dat_o};
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got %h expected no event", act);
         end else begin
            exp = sb.pop_front();
            if (act !== exp) begin
               errors++;
               $display("FAIL sb_event: got %h expected %h", act, exp);
            end
         end
      end
   end

   // single transfer by master m while the other master is idle; slave terminates on strobe cycle n
   task automatic xfer(input int m, input logic we, input logic [31:0] adr, input int n,
                       input logic [2:0] term, input logic [31:0] rdat);
      int k = 0;
      m_cyc_i[m] = 1'b1;
      m_stb_i[m] = 1'b1;
      m_we_i[m]  = we;
      m_adr_i[32*m +: 32] = adr;
      m_sel_i[4*m +: 4]   = 4'hF;
      m_dat_i[32*m +: 32] = ~adr;
      for (int i = 0; i < 64 && k < n; i++) begin
         #2;
         if (i == 0) chk("lat_idle", s_cyc_o, 0);
         if (i == 1) chk("lat_grant", s_cyc_o, 1);
         if (s_stb_o) k++;
         if (k == n) begin
            {ack_r, s_err_i, s_rty_i} = term;
            s_dat_i = rdat;
         end
         @(posedge clk_i); #1;
         {ack_r, s_err_i, s_rty_i} = '0;
         s_dat_i = '0;
      end
      chk("xfer_done", k, n);
      chk("cnt_clr", dut.cnt, 0);
      m_cyc_i[m] = 1'b0;
      m_stb_i[m] = 1'b0;
      @(posedge clk_i); #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int done[2];
      logic [1:0] a;
      #1;
      chk("rst_out", {s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_rty_o, timeout_o, s_adr_o}, 0);
      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1'b1;
      @(posedge clk_i); #1;
      // read 0x1000 by master 0, ack on the 2nd strobe cycle
      sb.push_back(mk(2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0000_1000, 32'hCAFE_0001));
      xfer(0, 1'b0, 32'h0000_1000, 2, 3'b100, 32'hCAFE_0001);
      // slave ERR then RTY to master 0 with master 1 idle
      sb.push_back(mk(2'b00, 2'b01, 2'b00, 1'b0, 1'b1, 32'h0000_4000, 32'h0));
      xfer(0, 1'b1, 32'h0000_4000, 1, 3'b010, 32'h0);
      sb.push_back(mk(2'b00, 2'b00, 2'b01, 1'b0, 1'b1, 32'h0000_4004, 32'h0));
      xfer(0, 1'b1, 32'h0000_4004, 1, 3'b001, 32'h0);
      // ack on exactly the 16th strobe cycle beats the watchdog
      sb.push_back(mk(2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0000_5000, 32'h1234_5678));
      xfer(0, 1'b0, 32'h0000_5000, 16, 3'b100, 32'h1234_5678);
      // master 1 strobes a missing slave: watchdog fires after 16 strobe cycles
      m_cyc_i[1] = 1'b1;
      m_stb_i[1] = 1'b1;
      m_we_i[1]  = 1'b0;
      m_adr_i[63:32] = 32'hDEAD_0000;
      m_sel_i[7:4]   = 4'hF;
      sb.push_back(mk(2'b00, 2'b10, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0));
      repeat (16) @(posedge clk_i);
      #2 chk("to_pre", {timeout_o, s_cyc_o}, 2'b01);
      @(posedge clk_i);
      #2 chk("to_pulse", {timeout_o, s_cyc_o, s_stb_o}, 3'b100);
      @(posedge clk_i);
      #2 chk("to_rebusy", {timeout_o, s_cyc_o}, 2'b01);
      @(posedge clk_i); #1;
      m_cyc_i[1] = 1'b0;
      m_stb_i[1] = 1'b0;
      @(posedge clk_i); #1;
      // asynchronous reset in the middle of a BUSY cycle
      m_cyc_i[0] = 1'b1;
      m_stb_i[0] = 1'b1;
      m_adr_i[31:0] = 32'h0000_3000;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      ack_r = 1'b1;
      #1 chk("pre_rst", {s_cyc_o, s_stb_o, m_ack_o}, 4'b1101);
      rst_ni = 1'b0;
      #1 chk("async_rst", {s_cyc_o, s_stb_o, m_ack_o}, 4'b0000);
      ack_r = 1'b0;
      m_cyc_i = 2'b11;
      m_stb_i = 2'b11;
      m_we_i  = 2'b11;
      m_adr_i = {base(1, 0), base(0, 0)};
      m_dat_i = {32'h1111_0000, 32'h0000_1111};
      m_sel_i = 8'hFF;
      for (int i = 0; i < 8; i++)
         sb.push_back(mk(i % 2 ? 2'b10 : 2'b01, 2'b00, 2'b00, 1'b0, 1'b1, base(i % 2, i / 2), 32'h0));
      @(posedge clk_i);
      #2 rst_ni = 1'b1;
      // both masters request continuously; the first tie after reset goes to master 0
      auto_ack = 1'b1;
      done = '{0, 0};
      for (int t = 0; t < 200 && (done[0] < 4 || done[1] < 4); t++) begin
         @(negedge clk_i);
         a = m_ack_o;
         chk("ack_excl", a == 2'b11, 0);
         if (s_stb_o) chk("stb_owner", s_adr_o, base((done[0] + done[1]) % 2, done[(done[0] + done[1]) % 2]));
         @(posedge clk_i); #1;
         for (int m = 0; m < 2; m++) begin
            if (a[m]) begin
               done[m]++;
               m_cyc_i[m] = 1'b0;
               m_stb_i[m] = 1'b0;
            end else if (!m_cyc_i[m] && done[m] < 4) begin
               m_cyc_i[m] = 1'b1;
               m_stb_i[m] = 1'b1;
               m_adr_i[32*m +: 32] = base(m, done[m]);
            end
         end
      end
      chk("rr_done", done[0] + done[1], 8);
      auto_ack = 1'b0;
      m_cyc_i = '0;
      m_stb_i = '0;
      repeat (4) @(posedge clk_i);
      #1 chk("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
